// File: rtl/cpu_pkg.sv
// Types and constants shared by the fetch stage and the control decoder.
// The fetch FSM states and the ISA opcodes live here so both sides agree on encodings.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = {12'h000, 5'd0, 3'b000, 5'd0, OP_IMM};

    function automatic logic is_branch(input logic [31:0] word);
        return word[6:0] == OP_BRANCH;
    endfunction

endpackage

// File: rtl/next_pc.sv
// Next fetch address: sequential PC+4 or taken-branch PC+ImmOp, word aligned.
// Pure combinational; wraps modulo 2^ADDRESS_WIDTH.
module next_pc #(
    parameter int ADDRESS_WIDTH = 32
) (
    input  logic [ADDRESS_WIDTH-1:0] pc,
    input  logic [ADDRESS_WIDTH-1:0] imm,
    input  logic                     pcsrc,
    output logic [ADDRESS_WIDTH-1:0] next
);

    logic [ADDRESS_WIDTH-1:0] sum;

    always_comb begin
        sum  = pcsrc ? (pc + imm) : (pc + ADDRESS_WIDTH'(4));
        // Fetch addresses are always word aligned, even for odd branch targets.
        next = sum & ~ADDRESS_WIDTH'(3);
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the architectural PC, issues one memory request at a time
// and presents a registered instruction to decode until it is accepted.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int                     ADDRESS_WIDTH = 32,
    parameter int                     DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     PCsrc,
    input  logic [ADDRESS_WIDTH-1:0] ImmOp,
    output logic                     imem_req,
    output logic [ADDRESS_WIDTH-1:0] imem_addr,
    input  logic                     imem_rvalid,
    input  logic [DATA_WIDTH-1:0]    imem_rdata,
    output logic [DATA_WIDTH-1:0]    instr,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [ADDRESS_WIDTH-1:0] PC
);

    fetch_state_t             state;
    logic [ADDRESS_WIDTH-1:0] fetch_pc;
    logic [ADDRESS_WIDTH-1:0] pc_next;

    next_pc #(
        .ADDRESS_WIDTH(ADDRESS_WIDTH)
    ) u_next_pc (
        .pc   (PC),
        .imm  (ImmOp),
        .pcsrc(PCsrc),
        .next (pc_next)
    );

    // All outputs are registered; imem_addr is loaded together with fetch_pc so it is
    // already stable on the first cycle imem_req is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            imem_req    <= 1'b0;
            imem_addr   <= RESET_PC;
            fetch_pc    <= RESET_PC;
            PC          <= RESET_PC;
            instr       <= DATA_WIDTH'(NOP_INSTR);
            instr_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state     <= REQ;
                    imem_req  <= 1'b1;
                    imem_addr <= fetch_pc;
                end
                REQ: begin
                    if (imem_rvalid) begin
                        state       <= HOLD;
                        imem_req    <= 1'b0;
                        instr       <= imem_rdata;
                        PC          <= fetch_pc;
                        instr_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    // Spurious imem_rvalid is ignored here; only the consumer moves us on.
                    if (instr_ready) begin
                        state       <= REQ;
                        fetch_pc    <= pc_next;
                        imem_addr   <= pc_next;
                        imem_req    <= 1'b1;
                        instr_valid <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: drives the memory and consumer sides cycle by cycle
// and compares outputs against hand-computed values.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        PCsrc;
    logic [31:0] ImmOp;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] PC;

    int n_cmp = 0;
    int n_bad = 0;

    fetch_unit #(
        .ADDRESS_WIDTH(32),
        .DATA_WIDTH   (32),
        .RESET_PC     (32'h0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .PCsrc      (PCsrc),
        .ImmOp      (ImmOp),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .PC         (PC)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[19:0], 12'h093};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds reset over two edges and releases it just after an edge; the next edge is cycle 1.
    task automatic do_reset();
        rst         = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hDEAD_BEEF;
        instr_ready = 1'b0;
        PCsrc       = 1'b0;
        ImmOp       = 32'h0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b expected 0", imem_req); end
        n_cmp++; if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL reset_addr: got %h expected 00000000", imem_addr); end
        n_cmp++; if (instr !== 32'h0000_0013) begin n_bad++; $display("FAIL reset_instr: got %h expected 00000013", instr); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
        n_cmp++; if (PC !== 32'h0) begin n_bad++; $display("FAIL reset_pc: got %h expected 00000000", PC); end
    endtask

    task automatic test_sequential();
        logic [31:0] a;
        do_reset();
        instr_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            a = 32'(k * 4);
            tick();
            n_cmp++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL seq_req c%0d: got %b expected 1", 2*k+1, imem_req); end
            n_cmp++; if (imem_addr !== a) begin n_bad++; $display("FAIL seq_addr c%0d: got %h expected %h", 2*k+1, imem_addr, a); end
            n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL seq_valid_lo c%0d: got %b expected 0", 2*k+1, instr_valid); end
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(a);
            tick();
            imem_rvalid = 1'b0;
            imem_rdata  = 32'hDEAD_BEEF;
            n_cmp++; if (instr_valid !== 1'b1) begin n_bad++; $display("FAIL seq_valid c%0d: got %b expected 1", 2*k+2, instr_valid); end
            n_cmp++; if (PC !== a) begin n_bad++; $display("FAIL seq_pc c%0d: got %h expected %h", 2*k+2, PC, a); end
            n_cmp++; if (instr !== mem_word(a)) begin n_bad++; $display("FAIL seq_instr c%0d: got %h expected %h", 2*k+2, instr, mem_word(a)); end
            n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL seq_req_lo c%0d: got %b expected 0", 2*k+2, imem_req); end
        end
    endtask

    task automatic test_wait_states();
        do_reset();
        instr_ready = 1'b1;
        tick();
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(32'h0);
        tick();
        imem_rvalid = 1'b0;
        for (int w = 0; w < 4; w++) begin
            tick();
            n_cmp++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL wait_req w%0d: got %b expected 1", w, imem_req); end
            n_cmp++; if (imem_addr !== 32'h4) begin n_bad++; $display("FAIL wait_addr w%0d: got %h expected 00000004", w, imem_addr); end
            n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL wait_valid w%0d: got %b expected 0", w, instr_valid); end
            if (w == 3) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(32'h4);
            end
        end
        tick();
        imem_rvalid = 1'b0;
        n_cmp++; if (instr_valid !== 1'b1) begin n_bad++; $display("FAIL wait_valid_rise: got %b expected 1", instr_valid); end
        n_cmp++; if (PC !== 32'h4) begin n_bad++; $display("FAIL wait_pc: got %h expected 00000004", PC); end
        n_cmp++; if (instr !== mem_word(32'h4)) begin n_bad++; $display("FAIL wait_instr: got %h expected %h", instr, mem_word(32'h4)); end
    endtask

    task automatic test_branch();
        do_reset();
        instr_ready = 1'b1;
        tick();
        imem_rvalid = 1'b1; imem_rdata = mem_word(32'h0);
        tick();
        imem_rvalid = 1'b0; PCsrc = 1'b1; ImmOp = 32'h20;
        tick();
        PCsrc = 1'b0; ImmOp = 32'h5555_5555;
        n_cmp++; if (imem_addr !== 32'h20) begin n_bad++; $display("FAIL br_fwd_addr: got %h expected 00000020", imem_addr); end
        imem_rvalid = 1'b1; imem_rdata = mem_word(32'h20);
        tick();
        imem_rvalid = 1'b0;
        n_cmp++; if (PC !== 32'h20) begin n_bad++; $display("FAIL br_pc20: got %h expected 00000020", PC); end
        PCsrc = 1'b1; ImmOp = 32'hFFFF_FFF8;
        tick();
        PCsrc = 1'b0; ImmOp = 32'h5555_5555;
        n_cmp++; if (imem_addr !== 32'h18) begin n_bad++; $display("FAIL br_back_addr: got %h expected 00000018", imem_addr); end
        imem_rvalid = 1'b1; imem_rdata = mem_word(32'h18);
        tick();
        imem_rvalid = 1'b0; PCsrc = 1'b1; ImmOp = 32'h8;
        tick();
        PCsrc = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = mem_word(32'h20);
        tick();
        imem_rvalid = 1'b0; PCsrc = 1'b0; ImmOp = 32'hFFFF_FFF8;
        n_cmp++; if (PC !== 32'h20) begin n_bad++; $display("FAIL br_pc20b: got %h expected 00000020", PC); end
        tick();
        n_cmp++; if (imem_addr !== 32'h24) begin n_bad++; $display("FAIL br_nt_addr: got %h expected 00000024", imem_addr); end
    endtask

    task automatic test_backpressure();
        do_reset();
        tick();
        imem_rvalid = 1'b1; imem_rdata = mem_word(32'h0);
        tick();
        imem_rvalid = 1'b0;
        PCsrc = 1'b1; ImmOp = 32'h100;
        for (int s = 0; s < 5; s++) begin
            if (s == 1) begin
                imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
            end else begin
                imem_rvalid = 1'b0;
            end
            tick();
            n_cmp++; if (instr_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid s%0d: got %b expected 1", s, instr_valid); end
            n_cmp++; if (instr !== mem_word(32'h0)) begin n_bad++; $display("FAIL bp_instr s%0d: got %h expected %h", s, instr, mem_word(32'h0)); end
            n_cmp++; if (PC !== 32'h0) begin n_bad++; $display("FAIL bp_pc s%0d: got %h expected 00000000", s, PC); end
            n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL bp_req s%0d: got %b expected 0", s, imem_req); end
        end
        imem_rvalid = 1'b0;
        PCsrc = 1'b0; instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        n_cmp++; if (imem_addr !== 32'h4) begin n_bad++; $display("FAIL bp_next_addr: got %h expected 00000004", imem_addr); end
        n_cmp++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL bp_next_req: got %b expected 1", imem_req); end
    endtask

    task automatic test_wrap();
        do_reset();
        instr_ready = 1'b1;
        tick();
        imem_rvalid = 1'b1; imem_rdata = mem_word(32'h0);
        tick();
        imem_rvalid = 1'b0; PCsrc = 1'b1; ImmOp = 32'hFFFF_FFFC;
        tick();
        PCsrc = 1'b0;
        n_cmp++; if (imem_addr !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_top_addr: got %h expected fffffffc", imem_addr); end
        imem_rvalid = 1'b1; imem_rdata = mem_word(32'hFFFF_FFFC);
        tick();
        imem_rvalid = 1'b0;
        tick();
        n_cmp++; if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL wrap_zero_addr: got %h expected 00000000", imem_addr); end
        imem_rvalid = 1'b1; imem_rdata = mem_word(32'h0);
        tick();
        imem_rvalid = 1'b0; PCsrc = 1'b1; ImmOp = 32'h103;
        tick();
        PCsrc = 1'b0;
        n_cmp++; if (imem_addr !== 32'h100) begin n_bad++; $display("FAIL wrap_align_addr: got %h expected 00000100", imem_addr); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        instr_ready = 1'b1;
        tick();
        imem_rvalid = 1'b1; imem_rdata = mem_word(32'h0);
        tick();
        imem_rvalid = 1'b0; PCsrc = 1'b1; ImmOp = 32'h40;
        tick();
        PCsrc = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = mem_word(32'h40);
        tick();
        imem_rvalid = 1'b0;
        tick();
        n_cmp++; if (imem_addr !== 32'h44) begin n_bad++; $display("FAIL mid_pre_addr: got %h expected 00000044", imem_addr); end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (instr !== 32'h0000_0013) begin n_bad++; $display("FAIL mid_instr: got %h expected 00000013", instr); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL mid_valid: got %b expected 0", instr_valid); end
        n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL mid_req: got %b expected 0", imem_req); end
        n_cmp++; if (PC !== 32'h0) begin n_bad++; $display("FAIL mid_pc: got %h expected 00000000", PC); end
        n_cmp++; if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL mid_addr: got %h expected 00000000", imem_addr); end
        tick();
        rst = 1'b0;
        tick();
        n_cmp++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL mid_restart_req: got %b expected 1", imem_req); end
        n_cmp++; if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL mid_restart_addr: got %h expected 00000000", imem_addr); end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_sequential();
        test_wait_states();
        test_branch();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
